// File: rtl/bsg_dlatch_wr_arb.sv
// Write controller and round-robin arbiter for a shared bank of latches.
// Each write is a one-cycle latch-enable pulse (WR) followed by a one-cycle
// data-hold cycle (HLD). A clear sweep writes zero into every entry in turn.
module bsg_dlatch_wr_arb #(
  parameter int unsigned els_p     = 16,
  parameter int unsigned width_p   = 16,
  parameter int unsigned num_req_p = 4,
  localparam int unsigned lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [num_req_p-1:0]           v_i,
  input  logic [num_req_p*lg_els_lp-1:0] addr_i,
  input  logic [num_req_p*width_p-1:0]   data_i,
  output logic [num_req_p-1:0]           ready_o,
  input  logic                           clear_i,
  output logic                           clear_done_o,
  output logic                           busy_o,
  output logic [els_p-1:0]               latch_en_o,
  output logic [width_p-1:0]             latch_data_o
);

  localparam int unsigned lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam logic [lg_els_lp-1:0] last_ent_lp = lg_els_lp'(els_p - 1);

  localparam logic [2:0] st_idle = 3'd0;
  localparam logic [2:0] st_wr   = 3'd1;
  localparam logic [2:0] st_hld  = 3'd2;
  localparam logic [2:0] st_cwr  = 3'd3;
  localparam logic [2:0] st_chld = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [lg_req_lp-1:0] rr_q, rr_d;
  logic                 clr_pend_q, clr_pend_d;
  logic [lg_els_lp-1:0] clr_cnt_q, clr_cnt_d;
  logic [lg_els_lp-1:0] addr_q, addr_d;
  logic [width_p-1:0]   data_q, data_d;
  logic [els_p-1:0]     latch_en_q, latch_en_d;
  logic [width_p-1:0]   latch_data_q, latch_data_d;
  logic                 clear_done_q, clear_done_d;

  logic                 win_found;
  logic [lg_req_lp-1:0] win_idx;
  logic [lg_req_lp-1:0] cand;
  logic [num_req_p-1:0] grant_oh;
  logic [lg_els_lp-1:0] win_addr;
  logic [width_p-1:0]   win_data;
  logic [num_req_p-1:0] ready_c;

  // One-hot decode of an entry index; out-of-range indices decode to zero.
  function automatic logic [els_p-1:0] decode(input logic [lg_els_lp-1:0] a);
    logic [els_p-1:0] dec;
    for (int unsigned i = 0; i < els_p; i++) begin
      dec[i] = (32'(a) == i);
    end
    return dec;
  endfunction

  // Round-robin search starting at the pointer, wrapping modulo num_req_p.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      cand = lg_req_lp'((32'(rr_q) + k) % num_req_p);
      if (!win_found && v_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Winner's one-hot grant and its address/data slices.
  always_comb begin
    grant_oh = '0;
    win_addr = '0;
    win_data = '0;
    for (int unsigned r = 0; r < num_req_p; r++) begin
      if (win_found && (32'(win_idx) == r)) begin
        grant_oh[r] = 1'b1;
        win_addr    = addr_i[r*lg_els_lp +: lg_els_lp];
        win_data    = data_i[r*width_p +: width_p];
      end
    end
  end

  // Next-state, grant and next-output logic.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    clr_pend_d   = clr_pend_q;
    clr_cnt_d    = clr_cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    ready_c      = '0;
    latch_en_d   = '0;
    latch_data_d = '0;
    clear_done_d = 1'b0;

    unique case (state_q)
      st_idle, st_hld: begin
        // Pending clear beats any request at an accept point.
        if (clr_pend_q) begin
          state_d    = st_cwr;
          clr_cnt_d  = '0;
          clr_pend_d = 1'b0;
        end else if (win_found) begin
          ready_c = grant_oh;
          state_d = st_wr;
          addr_d  = win_addr;
          data_d  = win_data;
          rr_d    = lg_req_lp'((32'(win_idx) + 1) % num_req_p);
        end else begin
          state_d = st_idle;
        end
      end
      st_wr:  state_d = st_hld;
      st_cwr: state_d = st_chld;
      st_chld: begin
        if (clr_cnt_q == last_ent_lp) begin
          state_d = st_idle;
        end else begin
          clr_cnt_d = clr_cnt_q + lg_els_lp'(1);
          state_d   = st_cwr;
        end
      end
      default: state_d = st_idle;
    endcase

    // A clear request outside a sweep is remembered until the next accept point.
    if (clear_i && (state_q != st_cwr) && (state_q != st_chld)) begin
      clr_pend_d = 1'b1;
    end

    // Outputs for the coming cycle are precomputed so they leave flops directly.
    case (state_d)
      st_wr: begin
        latch_en_d   = decode(addr_d);
        latch_data_d = data_d;
      end
      st_hld:  latch_data_d = data_d;
      st_cwr:  latch_en_d   = decode(clr_cnt_d);
      st_chld: clear_done_d = (clr_cnt_d == last_ent_lp);
      default: ;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= st_idle;
      rr_q         <= '0;
      clr_pend_q   <= 1'b0;
      clr_cnt_q    <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      latch_en_q   <= '0;
      latch_data_q <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      clr_pend_q   <= clr_pend_d;
      clr_cnt_q    <= clr_cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      latch_en_q   <= latch_en_d;
      latch_data_q <= latch_data_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign ready_o      = ready_c;
  assign latch_en_o   = latch_en_q;
  assign latch_data_o = latch_data_q;
  assign clear_done_o = clear_done_q;
  assign busy_o       = (state_q != st_idle) || clr_pend_q;

endmodule

// File: tb/tb_bsg_dlatch_wr_arb.sv
// Bench for bsg_dlatch_wr_arb: a cycle-schedule model predicts every output.
module tb_bsg_dlatch_wr_arb;
  localparam int unsigned ELS = 16;
  localparam int unsigned W   = 16;
  localparam int unsigned NR  = 4;
  localparam int unsigned AW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     v;
  logic [NR*AW-1:0]  addr;
  logic [NR*W-1:0]   data;
  logic              clr;
  logic [NR-1:0]     ready_o;
  logic              clear_done_o;
  logic              busy_o;
  logic [ELS-1:0]    latch_en_o;
  logic [W-1:0]      latch_data_o;

  bsg_dlatch_wr_arb #(.els_p(ELS), .width_p(W), .num_req_p(NR)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .addr_i(addr), .data_i(data),
    .ready_o(ready_o), .clear_i(clr), .clear_done_o(clear_done_o), .busy_o(busy_o),
    .latch_en_o(latch_en_o), .latch_data_o(latch_data_o)
  );

  always #5 clk = ~clk;

  // Model: a queue of expected per-cycle outputs; empty queue means idle.
  typedef struct {
    logic [ELS-1:0] en;
    logic [W-1:0]   dat;
    bit             done;
    bit             acc;
    bit             sweep;
  } slot_t;

  slot_t          sq[$];
  int             rr_m;
  bit             pend_m;
  bit             after_rst;
  logic [ELS-1:0] e_en;
  logic [W-1:0]   e_data;
  bit             e_done, e_busy, e_acc, e_idle;
  logic [NR-1:0]  e_ready;
  int             e_win;
  int             checks = 0;
  int             errors = 0;

  function automatic void model_expect();
    if (sq.size() == 0) begin
      e_idle = 1; e_en = '0; e_data = '0; e_done = 0; e_busy = pend_m; e_acc = 1;
    end else begin
      e_idle = 0; e_en = sq[0].en; e_data = sq[0].dat; e_done = sq[0].done;
      e_busy = 1; e_acc = sq[0].acc;
    end
    e_win = -1;
    if (e_acc && !pend_m) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (rr_m + k) % NR;
        if (e_win < 0 && v[j]) e_win = j;
      end
    end
    e_ready = (e_win >= 0) ? (4'b0001 << e_win) : 4'b0000;
  endfunction

  task automatic settle();
    #1;
    model_expect();
  endtask

  // Advance the model across one posedge, then wait for the next negedge.
  task automatic tick();
    bit cur_acc, cur_sweep;
    slot_t s;
    logic [AW-1:0] a;
    if (!rst_n) begin
      sq.delete(); rr_m = 0; pend_m = 0; after_rst = 1;
    end else begin
      after_rst = 0;
      cur_acc   = e_acc;
      cur_sweep = !e_idle && sq[0].sweep;
      if (!e_idle) void'(sq.pop_front());
      if (cur_acc) begin
        if (pend_m) begin
          pend_m = 0;
          for (int k = 0; k < ELS; k++) begin
            s.en = 16'h0001 << k; s.dat = '0; s.done = 0; s.acc = 0; s.sweep = 1;
            sq.push_back(s);
            s.en = '0; s.done = (k == ELS - 1);
            sq.push_back(s);
          end
        end else if (e_win >= 0) begin
          a = addr[e_win*AW +: AW];
          s.en = (a < ELS) ? (16'h0001 << a) : '0;
          s.dat = data[e_win*W +: W]; s.done = 0; s.acc = 0; s.sweep = 0;
          sq.push_back(s);
          s.en = '0; s.acc = 1;
          sq.push_back(s);
          rr_m = (e_win + 1) % NR;
        end
      end
      if (clr && !cur_sweep) pend_m = 1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    v = '0; clr = 0; rst_n = 1;
    for (int i = 0; i < 100 && !(sq.size() == 0 && !pend_m); i++) begin
      settle(); tick();
    end
    checks++;
    if (!(sq.size() == 0 && !pend_m)) begin
      errors++; $display("FAIL drain_timeout pending=%0d want 0", sq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 0; v = '0; clr = 0; addr = '0; data = '0;
    repeat (2) begin settle(); tick(); end
    rst_n = 1;
    settle();
    checks++; if (latch_en_o !== 16'h0) begin errors++; $display("FAIL rst_en got %h want 0", latch_en_o); end
    checks++; if (latch_data_o !== 16'h0) begin errors++; $display("FAIL rst_data got %h want 0", latch_data_o); end
    checks++; if (clear_done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", clear_done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
    checks++; if (ready_o !== 4'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready_o); end
    tick();
  endtask

  task automatic test_single_write();
    logic [ELS-1:0] x_en[4];
    logic [NR-1:0]  x_rdy[4];
    bit             x_busy[4];
    x_en  = '{16'h0000, 16'h0020, 16'h0000, 16'h0000};
    x_rdy = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};
    x_busy = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        v = 4'b0100; addr = NR*AW'($urandom); data = {$urandom, $urandom};
        addr[2*AW +: AW] = 4'd5; data[2*W +: W] = 16'hA5A5;
      end else v = '0;
      settle();
      checks++; if (ready_o !== x_rdy[c] || ready_o !== e_ready) begin errors++; $display("FAIL sw_ready c%0d got %b want %b", c, ready_o, x_rdy[c]); end
      checks++; if (latch_en_o !== x_en[c] || latch_en_o !== e_en) begin errors++; $display("FAIL sw_en c%0d got %h want %h", c, latch_en_o, x_en[c]); end
      checks++; if (busy_o !== x_busy[c]) begin errors++; $display("FAIL sw_busy c%0d got %b want %b", c, busy_o, x_busy[c]); end
      if (c == 1 || c == 2) begin
        checks++; if (latch_data_o !== 16'hA5A5) begin errors++; $display("FAIL sw_data c%0d got %h want a5a5", c, latch_data_o); end
      end
      tick();
    end
  endtask

  task automatic test_all_requesters();
    int grants[$];
    int x_order[5];
    logic [ELS-1:0] prev_en;
    x_order = '{0, 1, 2, 3, 0};
    rst_n = 0; v = '0; settle(); tick(); rst_n = 1;
    prev_en = '0;
    for (int c = 0; c < 10; c++) begin
      v = 4'b1111; addr = NR*AW'($urandom); data = {$urandom, $urandom};
      settle();
      checks++; if (ready_o !== e_ready) begin errors++; $display("FAIL all_ready c%0d got %b want %b", c, ready_o, e_ready); end
      checks++; if (latch_en_o !== e_en) begin errors++; $display("FAIL all_en c%0d got %h want %h", c, latch_en_o, e_en); end
      if (!e_idle) begin
        checks++; if (latch_data_o !== e_data) begin errors++; $display("FAIL all_data c%0d got %h want %h", c, latch_data_o, e_data); end
      end
      checks++; if (prev_en != '0 && latch_en_o != '0) begin errors++; $display("FAIL all_en_consec c%0d got %h want 0", c, latch_en_o); end
      prev_en = latch_en_o;
      if (ready_o != '0) for (int r = 0; r < NR; r++) if (ready_o[r]) grants.push_back(r);
      tick();
    end
    checks++; if (grants.size() != 5) begin errors++; $display("FAIL all_grant_count got %0d want 5", grants.size()); end
    for (int g = 0; g < 5 && g < grants.size(); g++) begin
      checks++; if (grants[g] != x_order[g]) begin errors++; $display("FAIL all_order g%0d got %0d want %0d", g, grants[g], x_order[g]); end
    end
    drain();
  endtask

  // Runs a clear scenario and checks the single clear_done pulse cycle.
  task automatic test_clear_in_write();
    int done_cnt, done_cyc;
    done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < 38; c++) begin
      v = (c == 0) ? 4'b0001 : ((c >= 3) ? NR'($urandom) : 4'b0000);
      clr = (c == 1); addr = NR*AW'($urandom); data = {$urandom, $urandom};
      settle();
      checks++; if (ready_o !== e_ready) begin errors++; $display("FAIL cw_ready c%0d got %b want %b", c, ready_o, e_ready); end
      checks++; if (latch_en_o !== e_en) begin errors++; $display("FAIL cw_en c%0d got %h want %h", c, latch_en_o, e_en); end
      checks++; if (clear_done_o !== e_done) begin errors++; $display("FAIL cw_done c%0d got %b want %b", c, clear_done_o, e_done); end
      if (!e_idle) begin
        checks++; if (latch_data_o !== e_data) begin errors++; $display("FAIL cw_data c%0d got %h want %h", c, latch_data_o, e_data); end
      end
      if (clear_done_o === 1'b1) begin done_cnt++; done_cyc = c; end
      tick();
    end
    checks++; if (done_cnt != 1 || done_cyc != 34) begin errors++; $display("FAIL cw_done_when got %0d pulses at %0d want 1 at 34", done_cnt, done_cyc); end
    drain();
  endtask

  task automatic test_clear_with_grant();
    int done_cyc;
    done_cyc = -1;
    for (int c = 0; c < 37; c++) begin
      v = (c == 0) ? 4'b0010 : 4'b0000; clr = (c == 0);
      addr = NR*AW'($urandom); data = {$urandom, $urandom};
      settle();
      if (c == 0) begin
        checks++; if (ready_o !== 4'b0010) begin errors++; $display("FAIL cg_grant got %b want 0010", ready_o); end
      end
      checks++; if (latch_en_o !== e_en) begin errors++; $display("FAIL cg_en c%0d got %h want %h", c, latch_en_o, e_en); end
      checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL cg_busy c%0d got %b want %b", c, busy_o, e_busy); end
      if (clear_done_o === 1'b1) done_cyc = c;
      tick();
    end
    checks++; if (done_cyc != 34) begin errors++; $display("FAIL cg_done_when got %0d want 34", done_cyc); end
    drain();
  endtask

  task automatic test_reset_mid_clear();
    bit hit;
    hit = 0;
    v = '0; clr = 1; settle(); tick(); clr = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      settle();
      if (!e_idle && sq[0].sweep && sq[0].en == 16'h0080) begin
        hit = 1;
        checks++; if (latch_en_o !== 16'h0080) begin errors++; $display("FAIL rc_en7 got %h want 0080", latch_en_o); end
        rst_n = 0;
      end
      tick();
    end
    checks++; if (!hit) begin errors++; $display("FAIL rc_timeout got no clr_cnt 7 want one"); end
    rst_n = 1; v = 4'b1111; addr = NR*AW'($urandom); data = {$urandom, $urandom};
    settle();
    checks++; if (latch_en_o !== 16'h0) begin errors++; $display("FAIL rc_en got %h want 0", latch_en_o); end
    checks++; if (latch_data_o !== 16'h0) begin errors++; $display("FAIL rc_data got %h want 0", latch_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rc_busy got %b want 0", busy_o); end
    checks++; if (ready_o !== 4'b0001) begin errors++; $display("FAIL rc_grant got %b want 0001", ready_o); end
    tick();
    v = '0;
    for (int c = 0; c < 40; c++) begin
      settle();
      checks++; if (clear_done_o !== 1'b0) begin errors++; $display("FAIL rc_nodone c%0d got %b want 0", c, clear_done_o); end
      tick();
    end
    drain();
  endtask

  task automatic test_late_request();
    for (int c = 0; c < 4; c++) begin
      addr = NR*AW'($urandom); data = {$urandom, $urandom};
      if (c == 0) begin v = 4'b0001; addr[0 +: AW] = 4'd3; data[0 +: W] = 16'h1111; end
      else if (c < 3) begin v = 4'b1000; addr[3*AW +: AW] = 4'd9; data[3*W +: W] = 16'hBEEF; end
      else v = '0;
      settle();
      checks++; if (ready_o !== e_ready) begin errors++; $display("FAIL lr_ready c%0d got %b want %b", c, ready_o, e_ready); end
      if (c == 1) begin
        checks++; if (ready_o !== 4'b0000 || latch_data_o !== 16'h1111) begin errors++; $display("FAIL lr_wr got %b/%h want 0000/1111", ready_o, latch_data_o); end
      end
      if (c == 2) begin
        checks++; if (ready_o !== 4'b1000 || latch_data_o !== 16'h1111) begin errors++; $display("FAIL lr_hld got %b/%h want 1000/1111", ready_o, latch_data_o); end
      end
      if (c == 3) begin
        checks++; if (latch_en_o !== 16'h0200 || latch_data_o !== 16'hBEEF) begin errors++; $display("FAIL lr_wr2 got %h/%h want 0200/beef", latch_en_o, latch_data_o); end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      v = NR'($urandom); addr = NR*AW'($urandom); data = {$urandom, $urandom};
      clr = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      settle();
      checks++; if (ready_o !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, ready_o, e_ready); end
      checks++; if (latch_en_o !== e_en) begin errors++; $display("FAIL rnd_en c%0d got %h want %h", c, latch_en_o, e_en); end
      checks++; if (clear_done_o !== e_done) begin errors++; $display("FAIL rnd_done c%0d got %b want %b", c, clear_done_o, e_done); end
      checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy_o, e_busy); end
      if (!e_idle || after_rst) begin
        checks++; if (latch_data_o !== e_data) begin errors++; $display("FAIL rnd_data c%0d got %h want %h", c, latch_data_o, e_data); end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    rst_n = 0; v = '0; clr = 0; addr = '0; data = '0;
    rr_m = 0; pend_m = 0; after_rst = 0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_all_requesters();
    test_clear_in_write();
    test_clear_with_grant();
    test_reset_mid_clear();
    test_late_request();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_dlatch_wr_arb.md
Name: bsg_dlatch_wr_arb

Overview:
Write controller and round-robin arbiter for a shared bank of level-sensitive latches (els_p entries x width_p bits). It accepts write requests from num_req_p requesters and registers the winning address and data in flops. It then sequences each write as a one-cycle latch-enable pulse followed by a one-cycle data-hold cycle, so that setup and hold around the transparent window are met. It also provides a sweep that clears every entry to zero. It sits between requester logic and the latch array, and drives the array's per-entry gates and the shared write data.

Parameters:
els_p, 16, number of latch entries.
width_p, 16, data width of each entry.
num_req_p, 4, number of requesters.
lg_els_lp, $clog2(els_p), derived localparam; address width.

Ports:
clk_i  in  1  clock; all state updates on posedge.
reset_n_i  in  1  synchronous, active-low reset.
v_i  in  num_req_p  per-requester write valid.
addr_i  in  num_req_p*lg_els_lp  per-requester entry address; requester i occupies slice i.
data_i  in  num_req_p*width_p  per-requester write data; requester i occupies slice i.
ready_o  out  num_req_p  one-hot grant. Handshake completes on the cycle v_i[i] & ready_o[i] is high.
clear_i  in  1  request a full-array clear; a pulse is sufficient.
clear_done_o  out  1  one-cycle pulse when the clear sweep finishes.
busy_o  out  1  high in any state other than IDLE, or while a clear is pending.
latch_en_o  out  els_p  one-hot latch gate; drives the array's per-entry enables.
latch_data_o  out  width_p  registered write data to the array.

Behaviour:
- Reset is synchronous and active-low (reset_n_i==0 at posedge):
  - state=IDLE, rr pointer=0, clr_pend=0, clr_cnt=0.
  - Data/address registers are zeroed.
  - All outputs are 0.
  - Reset mid-write or mid-clear aborts immediately: latch_en_o is 0 the next cycle, and no clear_done_o pulse is produced.
- States:
  - IDLE
  - WR: latch_en_o[addr_r]=1, latch_data_o=data_r.
  - HLD: latch_en_o=0, latch_data_o still data_r.
  - CWR: latch_en_o[clr_cnt]=1, latch_data_o=0.
  - CHLD: latch_en_o=0, latch_data_o=0.
- Accept point: IDLE, or HLD.
  - At an accept point, clr_pend has priority. If clr_pend=1, next state is CWR with clr_cnt=0 and clr_pend cleared; ready_o=0 that cycle.
  - Otherwise ready_o is the round-robin winner among v_i. If the winner is i, addr_r/data_r load slice i, next state is WR, and rr pointer becomes (i+1) mod num_req_p.
  - If no request is valid, next state is IDLE.
- HLD with no new request goes to IDLE.
- Data register update occurs only at the HLD->WR edge, so data stays stable through the hold cycle.
- Throughput and latency:
  - Peak throughput is one write per 2 cycles.
  - Latch enable asserts the cycle after the handshake.
- ready_o is combinational from v_i and state; it is never asserted for a requester with v_i=0, and never in WR, CWR or CHLD.
- Round-robin: search starts at the rr pointer and wraps modulo num_req_p. The pointer advances only on a grant.
- Out-of-range address (addr >= els_p, only possible when els_p is not a power of two): the handshake completes and WR/HLD are sequenced, but latch_en_o stays all-zero.
- Clear sweep:
  - Sequence is CWR, CHLD for each clr_cnt = 0..els_p-1.
  - CHLD with clr_cnt<els_p-1 increments clr_cnt and goes to CWR.
  - On the last CHLD, clear_done_o=1 for that cycle and the next state is IDLE. Requests are not accepted in that cycle.
  - A full clear takes 2*els_p cycles from leaving the accept point.
- clear_i:
  - Sets clr_pend on any cycle that is not CWR or CHLD.
  - clear_i during a sweep is ignored.
  - clear_i in an accept cycle is registered and takes effect at the next accept point; it does not preempt the grant made in that cycle.
- latch_en_o is glitch-free: driven directly from registered one-hot state and address decode flops.

Test Plan:
- Reset, then a single write: requester 2 writes addr=5, data=16'hA5A5 -> ready_o=4'b0100 in cycle 0; cycle 1 latch_en_o=16'h0020 with data A5A5; cycle 2 latch_en_o=0 with data still A5A5; cycle 3 IDLE.
- All four requesters hold v_i=4'b1111 continuously -> grants come in order 0,1,2,3,0 on every second cycle; latch_en_o toggles each cycle and is never high on consecutive cycles.
- clear_i pulsed while a write is in WR -> the write finishes; then 32 cycles of sweep with latch_en_o=1<<k and data 0; clear_done_o pulses once on cycle 32; ready_o stays 0 throughout the sweep.
- clear_i and v_i[1] asserted together in IDLE -> requester 1 is granted first; the clear starts at the following HLD; clear_done_o fires 2+32 cycles after the grant.
- reset_n_i driven low during the CWR of clr_cnt=7 -> next cycle all outputs are 0 and the state is IDLE; no clear_done_o pulse; a subsequent request with rr pointer 0 is granted to requester 0.
- v_i toggled with no grant window (request arrives in WR) -> ready_o=0 in WR; the request is granted in the following HLD; data_r remains unchanged until WR.
